// File: rtl/aes_inv_round_ctrl.sv
// Sequencer for the iterative AES-128 decryption datapath: walks the shared
// InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns units one stage per cycle.
module aes_inv_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_start_valid,
  output logic                 o_start_ready,
  output logic                 o_load,
  output logic                 o_shift_active,
  output logic                 o_sub_active,
  output logic                 o_ark_active,
  output logic                 o_imc_active,
  output logic [KEY_IDX_W-1:0] o_key_index,
  output logic [KEY_IDX_W-1:0] o_round,
  output logic                 o_out_valid,
  input  logic                 i_out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_SUB,
    S_ARK,
    S_IMC,
    S_DONE
  } state_e;

  localparam logic [KEY_IDX_W-1:0] ROUNDS_L    = KEY_IDX_W'(NUM_ROUNDS);
  localparam logic [KEY_IDX_W-1:0] ROUNDS_M1_L = KEY_IDX_W'(NUM_ROUNDS - 1);

  state_e               state_q;
  logic [KEY_IDX_W-1:0] round_q;

  // The final round skips InvMixColumns, so round_q is only decremented in IMC
  // and can never wrap below zero.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start_valid) begin
            state_q <= S_LOAD;
            round_q <= ROUNDS_L;
          end
        end
        S_LOAD: begin
          state_q <= S_SHIFT;
          round_q <= ROUNDS_M1_L;
        end
        S_SHIFT: state_q <= S_SUB;
        S_SUB:   state_q <= S_ARK;
        S_ARK: begin
          if (round_q != '0) state_q <= S_IMC;
          else               state_q <= S_DONE;
        end
        S_IMC: begin
          state_q <= S_SHIFT;
          round_q <= round_q - 1'b1;
        end
        S_DONE: begin
          if (i_out_ready) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          round_q <= '0;
        end
      endcase
    end
  end

  // All outputs are pure decodes of registered state; no input reaches an output.
  assign o_start_ready  = (state_q == S_IDLE);
  assign o_load         = (state_q == S_LOAD);
  assign o_shift_active = (state_q == S_SHIFT);
  assign o_sub_active   = (state_q == S_SUB);
  assign o_ark_active   = (state_q == S_LOAD) || (state_q == S_ARK);
  assign o_imc_active   = (state_q == S_IMC);
  assign o_out_valid    = (state_q == S_DONE);
  assign o_round        = round_q;
  assign o_key_index    = (state_q == S_LOAD) ? ROUNDS_L :
                          (state_q == S_ARK)  ? round_q  : '0;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: default 10-round build plus a 2-round build.
module tb_aes_inv_round_ctrl;

  localparam logic [6:0] IDLE_V  = 7'b1000000;
  localparam logic [6:0] LOAD_V  = 7'b0100100;
  localparam logic [6:0] SHIFT_V = 7'b0010000;
  localparam logic [6:0] SUB_V   = 7'b0001000;
  localparam logic [6:0] ARK_V   = 7'b0000100;
  localparam logic [6:0] IMC_V   = 7'b0000010;
  localparam logic [6:0] DONE_V  = 7'b0000001;

  logic clock = 1'b0;
  logic resetN;
  logic startValid, outReady, startReady, load, shiftActive, subActive;
  logic arkActive, imcActive, outValid;
  logic [3:0] keyIndex, round;
  logic startValid2, outReady2, startReady2, load2, shiftActive2, subActive2;
  logic arkActive2, imcActive2, outValid2;
  logic [3:0] keyIndex2, round2;
  logic [6:0] flags, flags2;

  int checks = 0;
  int failures = 0;
  int imcSeen = 0;
  int lat;
  int n;
  int validSeen;

  always #5 clock = ~clock;

  aes_inv_round_ctrl #(.NUM_ROUNDS(10), .KEY_IDX_W(4)) dut (
    .i_clock(clock), .i_reset_n(resetN), .i_start_valid(startValid),
    .o_start_ready(startReady), .o_load(load), .o_shift_active(shiftActive),
    .o_sub_active(subActive), .o_ark_active(arkActive), .o_imc_active(imcActive),
    .o_key_index(keyIndex), .o_round(round), .o_out_valid(outValid),
    .i_out_ready(outReady)
  );

  aes_inv_round_ctrl #(.NUM_ROUNDS(2), .KEY_IDX_W(4)) dut2 (
    .i_clock(clock), .i_reset_n(resetN), .i_start_valid(startValid2),
    .o_start_ready(startReady2), .o_load(load2), .o_shift_active(shiftActive2),
    .o_sub_active(subActive2), .o_ark_active(arkActive2), .o_imc_active(imcActive2),
    .o_key_index(keyIndex2), .o_round(round2), .o_out_valid(outValid2),
    .i_out_ready(outReady2)
  );

  assign flags  = {startReady, load, shiftActive, subActive, arkActive, imcActive, outValid};
  assign flags2 = {startReady2, load2, shiftActive2, subActive2, arkActive2, imcActive2, outValid2};

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input bit useDut2, input logic [6:0] expFlags,
                             input int expKey, input int expRound);
    if (useDut2) begin
      checkValue({tag, "_flags"}, int'(flags2), int'(expFlags));
      checkValue({tag, "_key"}, int'(keyIndex2), expKey);
      checkValue({tag, "_round"}, int'(round2), expRound);
    end else begin
      checkValue({tag, "_flags"}, int'(flags), int'(expFlags));
      checkValue({tag, "_key"}, int'(keyIndex), expKey);
      checkValue({tag, "_round"}, int'(round), expRound);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic ready);
    startValid = start;
    outReady   = ready;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (imcActive) imcSeen++;
  endtask

  // Steps from LOAD until o_out_valid, bounded; expects 40 edges for the 10-round build.
  task automatic waitDone(input string tag, output int cycles);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 60) begin
      step();
      k++;
      checkValue({tag, "_onehot"},
                 int'($countones({shiftActive, subActive, arkActive, imcActive}) <= 1), 1);
      if (outValid) seen = 1;
    end
    cycles = k;
    checkValue({tag, "_latency"}, k, 40);
  endtask

  task automatic runBlock(input string tag, input bit holdStart, output int cycles);
    step();
    if (!holdStart) startValid = 1'b0;
    checkOutput({tag, "_load"}, 1'b0, LOAD_V, 10, 10);
    waitDone(tag, cycles);
  endtask

  initial begin
    // Reset with random inputs on both instances
    resetN = 1'b0;
    startValid2 = 1'b0;
    outReady2 = 1'b0;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      startValid2 = 1'($urandom_range(0, 1));
      outReady2   = 1'($urandom_range(0, 1));
      step();
      checkOutput("reset", 1'b0, IDLE_V, 0, 0);
      checkOutput("reset2", 1'b1, IDLE_V, 0, 0);
    end
    @(negedge clock);
    applyStimulus(1'b0, 1'b0);
    startValid2 = 1'b0;
    outReady2   = 1'b0;
    resetN = 1'b1;
    step();
    step();
    checkOutput("post_reset", 1'b0, IDLE_V, 0, 0);

    // Single block with the consumer always ready
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1);
    imcSeen = 0;
    n = 0;
    checkOutput("t2_load", 1'b0, LOAD_V, 10, 10);
    for (int r = 9; r >= 0; r--) begin
      step(); n++;
      checkOutput("t2_shift", 1'b0, SHIFT_V, 0, r);
      step(); n++;
      checkOutput("t2_sub", 1'b0, SUB_V, 0, r);
      step(); n++;
      checkOutput("t2_ark", 1'b0, ARK_V, r, r);
      if (r != 0) begin
        step(); n++;
        checkOutput("t2_imc", 1'b0, IMC_V, 0, r);
      end
    end
    step(); n++;
    checkOutput("t2_done", 1'b0, DONE_V, 0, 0);
    checkValue("t2_latency", n, 40);
    step();
    checkOutput("t2_idle", 1'b0, IDLE_V, 0, 0);
    checkValue("t2_imc_count", imcSeen, 9);

    // Back-pressure: consumer stalls 7 cycles, starts during DONE are ignored
    applyStimulus(1'b1, 1'b0);
    runBlock("t3", 1'b0, lat);
    checkOutput("t3_done", 1'b0, DONE_V, 0, 0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      checkOutput("t3_hold", 1'b0, DONE_V, 0, 0);
    end
    applyStimulus(1'b0, 1'b1);
    step();
    checkOutput("t3_release", 1'b0, IDLE_V, 0, 0);

    // Back-to-back with start held high
    applyStimulus(1'b1, 1'b1);
    runBlock("t4a", 1'b1, lat);
    step();
    checkOutput("t4_gap_idle", 1'b0, IDLE_V, 0, 0);
    step();
    checkOutput("t4_second_load", 1'b0, LOAD_V, 10, 10);
    applyStimulus(1'b0, 1'b1);
    waitDone("t4b", lat);
    step();
    checkOutput("t4_idle", 1'b0, IDLE_V, 0, 0);

    // Asynchronous reset in SUB of round 5
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 18; i++) step();
    checkOutput("t5_sub_r5", 1'b0, SUB_V, 0, 5);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("t5_async", 1'b0, IDLE_V, 0, 0);
    @(negedge clock);
    resetN = 1'b1;
    validSeen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (outValid) validSeen++;
    end
    checkValue("t5_no_valid", validSeen, 0);
    checkOutput("t5_idle", 1'b0, IDLE_V, 0, 0);
    applyStimulus(1'b1, 1'b1);
    runBlock("t5_rerun", 1'b0, lat);
    step();
    checkOutput("t5_rerun_idle", 1'b0, IDLE_V, 0, 0);

    // Two-round build
    outReady2   = 1'b1;
    startValid2 = 1'b1;
    step();
    startValid2 = 1'b0;
    checkOutput("t6_load", 1'b1, LOAD_V, 2, 2);
    step(); checkOutput("t6_shift1", 1'b1, SHIFT_V, 0, 1);
    step(); checkOutput("t6_sub1", 1'b1, SUB_V, 0, 1);
    step(); checkOutput("t6_ark1", 1'b1, ARK_V, 1, 1);
    step(); checkOutput("t6_imc1", 1'b1, IMC_V, 0, 1);
    step(); checkOutput("t6_shift0", 1'b1, SHIFT_V, 0, 0);
    step(); checkOutput("t6_sub0", 1'b1, SUB_V, 0, 0);
    step(); checkOutput("t6_ark0", 1'b1, ARK_V, 0, 0);
    step(); checkOutput("t6_done", 1'b1, DONE_V, 0, 0);
    step(); checkOutput("t6_idle", 1'b1, IDLE_V, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
